// File: rtl/ram_reader_pkg.sv
// Shared types and default widths for the burst RAM reader.
package ram_reader_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 12;
  localparam int DEF_COUNT_WIDTH   = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    FINISH  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_reader.sv
// Burst reader: fetches 'count' consecutive words from a registered-output
// RAM starting at 'base_addr' and presents them one at a time on a
// valid/ready stream, pulsing 'done' when the burst ends.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for start; ram_addr holds its last value
//   ADDR    | ram_addr = base + index is presented to the RAM
//   CAPTURE | RAM read data is valid; it is registered into out_data
//   HOLD    | word presented on out_*, waiting for out_ready
//   FINISH  | done pulse, one cycle, then back to IDLE
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]   count,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_wEn,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [COUNT_WIDTH-1:0]   out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [COUNT_WIDTH-1:0]   idx_q, idx_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0]   out_index_q, out_index_d;
  logic                     out_last_q, out_last_d;
  logic                     out_valid_q, out_valid_d;

  logic                     handshake;
  logic [COUNT_WIDTH-1:0]   idx_inc;

  assign handshake = out_valid_q & out_ready;
  assign idx_inc   = idx_q + CNT_ONE;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (count == '0) ? FINISH : ADDR;
        end
      end
      ADDR:    state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD: begin
        if (handshake) begin
          state_d = out_last_q ? FINISH : ADDR;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FINISH);
  end

  // Datapath next values: burst parameters, index, RAM address and output word.
  always_comb begin
    base_d      = base_q;
    count_d     = count_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = count;
          idx_d   = '0;
          // Address for index 0 is loaded now so it is already on the
          // RAM port throughout ADDR.
          addr_d  = base_addr;
        end
      end
      CAPTURE: begin
        out_data_d  = ram_dataOut;
        out_valid_d = 1'b1;
        out_index_d = idx_q;
        out_last_d  = (idx_q == (count_q - CNT_ONE));
      end
      HOLD: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          if (!out_last_q) begin
            idx_d  = idx_inc;
            // Wraps naturally at ADDRESS_WIDTH bits.
            addr_d = base_q + ADDRESS_WIDTH'(idx_inc);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      base_q      <= base_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ram_addr   = addr_q;
  assign ram_wEn    = 1'b0;
  assign ram_dataIn = '0;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_ram_reader.sv
// Bench for ram_reader: directed bursts against a small registered-read RAM,
// with a scoreboard queue per DUT checked by an independent monitor.
module tb_ram_reader;
  import ram_reader_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int CW    = 5;
  localparam int DEPTH = 20;
  localparam int AW2   = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] idx;
    logic          last;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // DUT 1: default widths, RAM depth 20
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] count = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_wEn;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  // DUT 2: 4-bit address, for wrap-around
  logic           start2 = 1'b0;
  logic [AW2-1:0] base_addr2 = '0;
  logic [CW-1:0]  count2 = '0;
  logic [AW2-1:0] ram_addr2;
  logic           ram_wEn2;
  logic [DW-1:0]  ram_dataIn2;
  logic [DW-1:0]  ram_dataOut2 = '0;
  logic           out_valid2;
  logic           out_ready2 = 1'b1;
  logic [DW-1:0]  out_data2;
  logic [CW-1:0]  out_index2;
  logic           out_last2;
  logic           busy2;
  logic           done2;

  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] mem2 [16];

  exp_t q1[$];
  exp_t q2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt1 = 0;
  int   done_cnt2 = 0;

  always #5 clk = ~clk;

  ram_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .ram_addr(ram_addr), .ram_wEn(ram_wEn), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done)
  );

  ram_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW2), .COUNT_WIDTH(CW)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base_addr2), .count(count2),
    .ram_addr(ram_addr2), .ram_wEn(ram_wEn2), .ram_dataIn(ram_dataIn2),
    .ram_dataOut(ram_dataOut2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_index(out_index2), .out_last(out_last2),
    .busy(busy2), .done(done2)
  );

  // Registered-read RAMs (read data valid one clock after the address)
  always @(posedge clk) begin
    ram_dataOut  <= (int'(ram_addr) < DEPTH) ? mem[ram_addr] : '0;
    ram_dataOut2 <= mem2[ram_addr2];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor for DUT 1: count done pulses, pop and compare on each handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (done) done_cnt1++;
        if (out_valid && out_ready) begin
          if (q1.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got index %0d data 0x%0h, expected no word", out_index, out_data);
          end else begin
            e = q1.pop_front();
            chk("word_data",  out_data,  e.data);
            chk("word_index", out_index, e.idx);
            chk("word_last",  out_last,  e.last);
            chk("word_addr",  ram_addr,  e.addr);
            chk("ram_wEn",    ram_wEn,   1'b0);
            chk("ram_dataIn", ram_dataIn, '0);
          end
        end
      end
    end
  end

  // Monitor for DUT 2
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (done2) done_cnt2++;
        if (out_valid2 && out_ready2) begin
          if (q2.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word2: got index %0d data 0x%0h, expected no word", out_index2, out_data2);
          end else begin
            e = q2.pop_front();
            chk("w2_data",  out_data2,  e.data);
            chk("w2_index", out_index2, e.idx);
            chk("w2_last",  out_last2,  e.last);
            chk("w2_addr",  ram_addr2,  e.addr[AW2-1:0]);
          end
        end
      end
    end
  end

  // Expected words for a DUT 1 burst: mem[a] = 0x100 + a
  task automatic push1(input logic [AW-1:0] b, input int c);
    exp_t e;
    logic [AW-1:0] a;
    for (int i = 0; i < c; i++) begin
      a      = b + AW'(i);
      e.addr = a;
      e.data = (int'(a) < DEPTH) ? (32'h100 + 32'(a)) : '0;
      e.idx  = CW'(i);
      e.last = (i == c - 1);
      q1.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic issue1(input logic [AW-1:0] b, input logic [CW-1:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done1(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_word1(input logic [CW-1:0] ix, input int budget);
    int n;
    n = 0;
    while (!(out_valid === 1'b1 && out_index === ix) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("word_reached", {out_valid, out_index}, {1'b1, ix});
  endtask

  initial begin
    int lat;
    logic [DW-1:0] sd;
    logic [CW-1:0] si;
    logic [AW-1:0] sa;
    exp_t e;

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 16; i++) mem2[i] = 32'h200 + 32'(i);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last",  out_last,  1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_done",      done,      1'b0);
    chk("rst_out_data",  out_data,  '0);
    chk("rst_out_index", out_index, '0);
    chk("rst_ram_addr",  ram_addr,  '0);
    reset = 1'b0;
    @(negedge clk);

    // Basic burst: base 2, count 4 -> 0x102..0x105, latency 3
    done_cnt1 = 0;
    push1(12'd2, 4);
    issue1(12'd2, 5'd4);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", lat, 3);
    wait_done1(40);
    chk("burst1_done_count", done_cnt1, 1);
    chk("burst1_queue_empty", q1.size(), 0);

    // count = 0, start held into the FINISH cycle (coincident with done)
    done_cnt1 = 0;
    base_addr = 12'd3;
    count = 5'd0;
    start = 1'b1;
    @(negedge clk);
    chk("cnt0_busy_c1", busy, 1'b1);
    chk("cnt0_done_c1", done, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("cnt0_busy_c2", busy, 1'b0);
    chk("cnt0_done_c2", done, 1'b0);
    repeat (3) @(negedge clk);
    chk("cnt0_done_count", done_cnt1, 1);

    // Stall 5 cycles on word 1, with a start pulse that must be ignored
    done_cnt1 = 0;
    push1(12'd5, 3);
    issue1(12'd5, 5'd3);
    wait_word1(5'd1, 20);
    out_ready = 1'b0;
    sd = out_data;
    si = out_index;
    sa = ram_addr;
    base_addr = 12'd0;
    count = 5'd1;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data",  out_data,  sd);
      chk("stall_index", out_index, si);
      chk("stall_addr",  ram_addr,  sa);
    end
    out_ready = 1'b1;
    wait_done1(40);
    chk("stall_done_count", done_cnt1, 1);
    chk("stall_queue_empty", q1.size(), 0);

    // Reset during HOLD of word 2, then a fresh burst
    push1(12'd0, 4);
    issue1(12'd0, 5'd4);
    wait_word1(5'd2, 20);
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy",      busy,      1'b0);
    chk("midrst_done",      done,      1'b0);
    q1.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    done_cnt1 = 0;
    push1(12'd10, 3);
    issue1(12'd10, 5'd3);
    wait_done1(40);
    chk("post_rst_done_count", done_cnt1, 1);
    chk("post_rst_queue_empty", q1.size(), 0);

    // Address wrap on the 4-bit instance: 14, 15, 0, 1
    done_cnt2 = 0;
    for (int i = 0; i < 4; i++) begin
      e.addr = AW'((14 + i) % 16);
      e.data = 32'h200 + 32'((14 + i) % 16);
      e.idx  = CW'(i);
      e.last = (i == 3);
      q2.push_back(e);
    end
    base_addr2 = 4'd14;
    count2 = 5'd4;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (done2 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("wrap_done_seen", done2, 1'b1);
    @(negedge clk);
    chk("wrap_done_count", done_cnt2, 1);
    chk("wrap_queue_empty", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
